mux: RTL and testbench
======================

Name: mux

Overview:
- Parameterized N-to-1 data multiplexer used throughout the floating-point datapath, e.g. the divider's exponent-decrement and mantissa-normalize selection.
- Provides a purely combinational select path, which existing datapath instances depend on.
- Also provides an optional registered copy of the selected word with enable and valid tracking, for pipelined users.

Parameters:
DATA_SIZE, 8, bit width of each data input and of the outputs; must be >= 1.
SELECT_SIZE, 1, bit width of the select port; must be >= 1.
NUM_INPUTS, 2**SELECT_SIZE, number of data inputs; legal range 1 .. 2**SELECT_SIZE.

Ports:
clk  input  1  rising-edge clock for the registered path.
rst_n  input  1  reset; asynchronous, active-low.
in  input  unpacked array [NUM_INPUTS-1:0] of DATA_SIZE  data inputs; in[k] is selected when port==k.
port  input  SELECT_SIZE  select index, unsigned.
en  input  1  load enable for the registered path.
out  output  DATA_SIZE  combinational selected word.
sel_err  output  1  combinational flag; 1 when port >= NUM_INPUTS.
out_q  output  DATA_SIZE  registered selected word.
sel_err_q  output  1  registered copy of sel_err.
valid_q  output  1  1 once out_q holds a word loaded since reset.

Behaviour:
- Combinational path, zero latency, independent of clk and rst_n:
  - out = in[port] when port < NUM_INPUTS.
  - Otherwise out = all zeros and sel_err = 1.
  - sel_err = 0 for every in-range port.
  - With NUM_INPUTS == 2**SELECT_SIZE, sel_err is constant 0.
- The combinational path must be glitch-tolerant pure logic: no latches, no clock dependence. Existing instances use only in/port/out and must work with clk tied low, rst_n tied high and en tied low.
- X/Z on port: out is don't-care. Simulation must not hang or error.
- Registered path, 1-cycle latency:
  - On posedge clk with en=1: out_q <= out, sel_err_q <= sel_err, valid_q <= 1.
  - On posedge clk with en=0: all registered outputs hold their values.
- Reset:
  - rst_n low forces out_q=0, sel_err_q=0, valid_q=0 immediately, without waiting for a clock edge.
  - Registers stay cleared while rst_n is low, regardless of en.
  - Reset asserted mid-operation discards the held word and clears valid_q.
  - After rst_n rises, the first posedge with en=1 loads and sets valid_q.
- Simultaneous events: a change of in/port in the same cycle as a clk edge captures the values settled before the edge. Standard setup semantics apply; no bypass.
- No arithmetic is performed. Data passes bit-exact, with no sign or width conversion.
- Elaboration check: fatal error if NUM_INPUTS < 1, NUM_INPUTS > 2**SELECT_SIZE, DATA_SIZE < 1 or SELECT_SIZE < 1.
- The implementation must be synthesizable and must not rely on vendor primitives.

Test Plan:
- Divider exponent config: DATA_SIZE=10, SELECT_SIZE=1, in[0]=10'd0, in[1]=10'd1.
  - port=0 -> out=0.
  - port=1 -> out=1, sel_err=0, with no clock activity.
- Divider mantissa config: DATA_SIZE=23, in[0]=23'h400001, in[1]=23'h000002.
  - Toggling port 0/1 -> out follows immediately, bit-exact.
- Partial population: SELECT_SIZE=3, NUM_INPUTS=5, in[k]=8'hA0+k.
  - port=4 -> out=8'hA4, sel_err=0.
  - port=6 -> out=8'h00, sel_err=1.
  - After an en=1 edge -> sel_err_q=1, out_q=0.
- Registered path:
  - rst_n=0 -> out_q=0 and valid_q=0 immediately, before any clock edge.
  - Release reset, port=1, in[1]=8'h5C, en=1, one edge -> out_q=8'h5C, valid_q=1.
  - en=0, change in[1] to 8'h33 -> out_q stays 8'h5C while out=8'h33.
- Async reset mid-operation: with out_q=8'h5C and valid_q=1, pulse rst_n low between clock edges -> out_q=0 and valid_q=0 immediately; registers stay cleared until the next en=1 edge after release.
- Random sweep: 200 random in/port vectors for DATA_SIZE=64, SELECT_SIZE=2 -> out == in[port] every vector; out_q equals the previous cycle's out whenever en was 1.

Source files
------------

// File: rtl/mux.sv
// N-to-1 data multiplexer: a zero-latency combinational select path plus an
// optional registered copy of the selected word with load enable and valid flag.

// One input leg: passes its data word only when the select addresses it.
module mux_leg #(
  parameter int DATA_SIZE   = 8,
  parameter int SELECT_SIZE = 1,
  parameter int IDX         = 0
) (
  input  logic [SELECT_SIZE-1:0] port,
  input  logic [DATA_SIZE-1:0]   data,
  output logic [DATA_SIZE-1:0]   masked
);
  logic hit;

  assign hit    = (port == SELECT_SIZE'(IDX));
  assign masked = data & {DATA_SIZE{hit}};
endmodule

module mux #(
  parameter int DATA_SIZE   = 8,
  parameter int SELECT_SIZE = 1,
  parameter int NUM_INPUTS  = 2**SELECT_SIZE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_SIZE-1:0]   in [NUM_INPUTS-1:0],
  input  logic [SELECT_SIZE-1:0] port,
  input  logic                   en,
  output logic [DATA_SIZE-1:0]   out,
  output logic                   sel_err,
  output logic [DATA_SIZE-1:0]   out_q,
  output logic                   sel_err_q,
  output logic                   valid_q
);

  if (DATA_SIZE < 1 || SELECT_SIZE < 1 || NUM_INPUTS < 1 ||
      (SELECT_SIZE < 31 && NUM_INPUTS > (1 << SELECT_SIZE))) begin : g_bad_cfg
    $fatal(1, "mux: illegal parameters DATA_SIZE=%0d SELECT_SIZE=%0d NUM_INPUTS=%0d",
           DATA_SIZE, SELECT_SIZE, NUM_INPUTS);
  end

  // AND-OR structure: each leg masks its word, the legs are OR-combined.
  // An out-of-range select hits no leg, so out falls to zero by construction.
  logic [NUM_INPUTS-1:0][DATA_SIZE-1:0] leg_data;

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_leg
    mux_leg #(
      .DATA_SIZE  (DATA_SIZE),
      .SELECT_SIZE(SELECT_SIZE),
      .IDX        (k)
    ) u_leg (
      .port  (port),
      .data  (in[k]),
      .masked(leg_data[k])
    );
  end

  always_comb begin
    out = '0;
    for (int k = 0; k < NUM_INPUTS; k++) out = out | leg_data[k];
  end

  if (SELECT_SIZE < 31 && NUM_INPUTS < (1 << SELECT_SIZE)) begin : g_partial
    localparam logic [SELECT_SIZE:0] NUM_W = (SELECT_SIZE+1)'(NUM_INPUTS);
    logic [SELECT_SIZE:0] port_ext;

    assign port_ext = {1'b0, port};
    assign sel_err  = (port_ext >= NUM_W);
  end else begin : g_full
    assign sel_err = 1'b0;
  end

  logic [DATA_SIZE-1:0] out_d;
  logic                 sel_err_d;
  logic                 valid_d;

  always_comb begin
    out_d     = out_q;
    sel_err_d = sel_err_q;
    valid_d   = valid_q;
    if (en) begin
      out_d     = out;
      sel_err_d = sel_err;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      sel_err_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      out_q     <= out_d;
      sel_err_q <= sel_err_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_mux.sv
// Bench for mux: directed checks on several configurations plus a randomized
// sweep whose registered results are scoreboarded against a reference model.
module tb_mux;
  int total = 0;
  int bad   = 0;

  logic clk  = 1'b0;
  logic tie0 = 1'b0;
  logic tie1 = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Divider exponent configuration, clock-free use
  logic [9:0] in_a [1:0];
  logic       port_a;
  logic [9:0] out_a, outq_a;
  logic       err_a, errq_a, vq_a;
  mux #(.DATA_SIZE(10), .SELECT_SIZE(1)) u_a (
    .clk(tie0), .rst_n(tie1), .in(in_a), .port(port_a), .en(tie0),
    .out(out_a), .sel_err(err_a), .out_q(outq_a), .sel_err_q(errq_a), .valid_q(vq_a));

  // Divider mantissa configuration
  logic [22:0] in_b [1:0];
  logic        port_b;
  logic [22:0] out_b, outq_b;
  logic        err_b, errq_b, vq_b;
  mux #(.DATA_SIZE(23), .SELECT_SIZE(1)) u_b (
    .clk(tie0), .rst_n(tie1), .in(in_b), .port(port_b), .en(tie0),
    .out(out_b), .sel_err(err_b), .out_q(outq_b), .sel_err_q(errq_b), .valid_q(vq_b));

  // Partially populated, registered path
  logic [7:0] in_c [4:0];
  logic [2:0] port_c;
  logic       rstc_n = 1'b0;
  logic       en_c   = 1'b0;
  logic [7:0] out_c, outq_c;
  logic       err_c, errq_c, vq_c;
  mux #(.DATA_SIZE(8), .SELECT_SIZE(3), .NUM_INPUTS(5)) u_c (
    .clk(clk), .rst_n(rstc_n), .in(in_c), .port(port_c), .en(en_c),
    .out(out_c), .sel_err(err_c), .out_q(outq_c), .sel_err_q(errq_c), .valid_q(vq_c));

  // Wide random sweep
  logic [63:0] in_d [3:0];
  logic [1:0]  port_d = 2'd0;
  logic        rstd_n = 1'b0;
  logic        en_d   = 1'b0;
  logic [63:0] out_d, outq_d;
  logic        err_d, errq_d, vq_d;
  mux #(.DATA_SIZE(64), .SELECT_SIZE(2)) u_d (
    .clk(clk), .rst_n(rstd_n), .in(in_d), .port(port_d), .en(en_d),
    .out(out_d), .sel_err(err_d), .out_q(outq_d), .sel_err_q(errq_d), .valid_q(vq_d));

  typedef struct { int cyc; logic [63:0] val; } exp_t;
  exp_t        exp_q [$];
  bit          sweep_on = 1'b0;
  bit          loaded   = 1'b0;
  logic [63:0] last_val = '0;

  function automatic logic [63:0] ref_d();
    return in_d[int'(port_d)];
  endfunction

  // Monitor: combinational result every cycle, registered result popped when due
  always @(negedge clk) begin
    if (sweep_on) begin
      exp_t e;
      chk("sweep_out", out_d, ref_d());
      chk("sweep_err", {63'd0, err_d}, 64'd0);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        last_val = e.val;
        loaded = 1'b1;
        chk("sweep_outq", outq_d, e.val);
      end else begin
        chk("sweep_hold", outq_d, last_val);
      end
      chk("sweep_valid", {63'd0, vq_d}, {63'd0, loaded});
      chk("sweep_errq", {63'd0, errq_d}, 64'd0);
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) in_d[k] = '0;
    for (int k = 0; k < 5; k++) in_c[k] = 8'hA0 + 8'(k);
    port_c = 3'd4;
    #1;
    rstd_n = 1'b1;

    // Registered path cleared while reset is low, before any clock edge
    chk("rst_outq", {56'd0, outq_c}, 64'd0);
    chk("rst_valid", {63'd0, vq_c}, 64'd0);
    chk("rst_errq", {63'd0, errq_c}, 64'd0);

    in_a[0] = 10'd0; in_a[1] = 10'd1;
    port_a = 1'b0; #1 chk("exp_p0", {54'd0, out_a}, 64'd0);
    port_a = 1'b1; #1 chk("exp_p1", {54'd0, out_a}, 64'd1);
    chk("exp_err", {63'd0, err_a}, 64'd0);

    in_b[0] = 23'h400001; in_b[1] = 23'h000002;
    for (int i = 0; i < 4; i++) begin
      port_b = 1'(i);
      #0.5 chk("mant_out", {41'd0, out_b}, (i % 2) ? 64'h2 : 64'h400001);
    end

    chk("part_p4", {56'd0, out_c}, 64'hA4);
    chk("part_p4_err", {63'd0, err_c}, 64'd0);
    port_c = 3'd6; #0.5
    chk("part_p6", {56'd0, out_c}, 64'h00);
    chk("part_p6_err", {63'd0, err_c}, 64'd1);
    port_c = 3'bxxx; #0.5;
    port_c = 3'd6;

    @(negedge clk) begin rstc_n = 1'b1; en_c = 1'b1; end
    @(posedge clk) #1;
    chk("part_errq", {63'd0, errq_c}, 64'd1);
    chk("part_outq", {56'd0, outq_c}, 64'd0);
    chk("part_valid", {63'd0, vq_c}, 64'd1);

    port_c = 3'd1; in_c[1] = 8'h5C;
    @(posedge clk) #1;
    chk("reg_outq", {56'd0, outq_c}, 64'h5C);
    chk("reg_valid", {63'd0, vq_c}, 64'd1);
    chk("reg_errq", {63'd0, errq_c}, 64'd0);

    en_c = 1'b0; in_c[1] = 8'h33; #1;
    chk("hold_out", {56'd0, out_c}, 64'h33);
    @(posedge clk) #1;
    chk("hold_outq", {56'd0, outq_c}, 64'h5C);

    #2 rstc_n = 1'b0; #1;
    chk("mid_rst_outq", {56'd0, outq_c}, 64'd0);
    chk("mid_rst_valid", {63'd0, vq_c}, 64'd0);
    #1 rstc_n = 1'b1;
    @(posedge clk) #1;
    chk("post_rst_outq", {56'd0, outq_c}, 64'd0);
    chk("post_rst_valid", {63'd0, vq_c}, 64'd0);
    en_c = 1'b1;
    @(posedge clk) #1;
    chk("reload_outq", {56'd0, outq_c}, 64'h33);
    chk("reload_valid", {63'd0, vq_c}, 64'd1);
    en_c = 1'b0;

    // Random sweep: stimulus pushes the expected registered word when loading
    for (int v = 0; v < 200; v++) begin
      @(posedge clk) #1;
      for (int k = 0; k < 4; k++) in_d[k] = {$urandom, $urandom};
      port_d = 2'($urandom_range(0, 3));
      en_d   = 1'($urandom_range(0, 1));
      if (en_d) exp_q.push_back('{cyc: cyc + 1, val: ref_d()});
      sweep_on = 1'b1;
    end
    @(posedge clk) #1 en_d = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 sweep_on = 1'b0;
    chk("sweep_drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
